// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: {cout,sum} = a + b + cin, computed LSB first, one bit
//   per clock through a single full-add cell and a carry flip-flop.
//   A start accepted in IDLE captures the operands; WIDTH clocks later the
//   result is published together with a one-cycle done pulse and then held
//   until the next completion (or reset).
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse: sum/cout newly valid
//   sum    out  WIDTH  result bits, held between completions
//   cout   out  1      carry out of bit WIDTH-1, held with sum
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa;

  // Single full-add cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s_bit;
    logic c_bit;
    s_bit = x ^ y ^ c;
    c_bit = (x & y) | (x & c) | (y & c);
    return {c_bit, s_bit};
  endfunction

  assign fa = full_add(sh_a[0], sh_b[0], carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      // done is a single-cycle pulse, even when a new start is accepted here.
      done <= 1'b0;
      if (start) begin
        sh_a  <= a;
        sh_b  <= b;
        carry <= cin;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= BUSY;
      end
    end else begin
      // One result bit per edge; the new bit enters the sum shifter at the MSB
      // so that after WIDTH edges bit 0 has arrived at position 0.
      done  <= 1'b0;
      carry <= fa[1];
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sh_s  <= {fa[0], sh_s[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      if (cnt == LAST_BIT) begin
        // Publish straight from the cell output so the result is visible in
        // the same cycle as done, and never partially updated before then.
        sum   <= {fa[0], sh_s[WIDTH-1:1]};
        cout  <= fa[1];
        done  <= 1'b1;
        busy  <= 1'b0;
        cnt   <= '0;
        state <= IDLE;
      end
    end
  end

endmodule
